// File: rtl/bcd_counter_n.sv
// Multi-digit BCD up/down counter with clear, validated parallel load and wrap/saturate mode.
// tc is combinational so it can drive the enable of a following stage on the same clock.
module bcd_counter_n #(
    parameter int unsigned DIGITS = 4,
    parameter bit          WRAP   = 1'b1
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    input  logic                  en_i,
    input  logic                  up_i,
    input  logic                  clear_i,
    input  logic                  load_i,
    input  logic [4*DIGITS-1:0]   load_val_i,
    output logic [4*DIGITS-1:0]   q_o,
    output logic                  tc_o,
    output logic                  load_err_o
);

    localparam int unsigned W = 4 * DIGITS;

    logic [W-1:0] q_q, q_d, q_step;
    logic         load_err_q, load_err_d;
    logic [3:0]   dig;
    logic         nine_run, zero_run;
    logic         all_nine, all_zero, load_ok, at_term;

    // Ripple the carry/borrow condition digit by digit within one cycle.
    always_comb begin
        q_step   = q_q;
        dig      = 4'd0;
        nine_run = 1'b1;
        zero_run = 1'b1;
        load_ok  = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            dig = q_q[4*i +: 4];
            if (up_i) begin
                if (nine_run) q_step[4*i +: 4] = (dig == 4'd9) ? 4'd0 : dig + 4'd1;
            end else begin
                if (zero_run) q_step[4*i +: 4] = (dig == 4'd0) ? 4'd9 : dig - 4'd1;
            end
            nine_run = nine_run & (dig == 4'd9);
            zero_run = zero_run & (dig == 4'd0);
            if (load_val_i[4*i +: 4] > 4'd9) load_ok = 1'b0;
        end
        all_nine = nine_run;
        all_zero = zero_run;
    end

    assign at_term = up_i ? all_nine : all_zero;

    always_comb begin
        q_d        = q_q;
        load_err_d = 1'b0;
        if (clear_i) begin
            q_d = '0;
        end else if (load_i) begin
            if (load_ok) q_d = load_val_i;
            else         load_err_d = 1'b1;
        end else if (en_i) begin
            // Saturating mode parks on the terminal value instead of wrapping.
            if (!(at_term && !WRAP)) q_d = q_step;
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            q_q        <= '0;
            load_err_q <= 1'b0;
        end else begin
            q_q        <= q_d;
            load_err_q <= load_err_d;
        end
    end

    assign q_o        = q_q;
    assign load_err_o = load_err_q;
    assign tc_o       = en_i & ~load_i & ~clear_i & at_term;

endmodule
